// File: rtl/router_pkg.sv
// Shared definitions for the router input port: FSM encoding, address
// geometry and the default inter-field padding length.
package router_pkg;

    localparam int ADDR_W         = 4;
    localparam int NUM_PORTS      = 16;
    localparam int PAD_CYCLES_DEF = 5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_PAD  = 3'd2,
        S_DATA = 3'd3,
        S_DROP = 3'd4
    } state_t;

endpackage

// File: rtl/router_input_port.sv
// Serial router input port: captures a 4-bit LSB-first destination address,
// checks the padding gap, then forwards the payload to Decode with 1-cycle latency.
module router_input_port
    import router_pkg::*;
#(
    parameter int PAD_CYCLES = PAD_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_n,
    input  logic              valid_n,
    input  logic              din,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_vld,
    output logic              frameo_n,
    output logic              valido_n,
    output logic              dout,
    output logic              pkt_err,
    output logic              busy,
    output logic [2:0]        fsm_state
);

    localparam int CNT_W = (PAD_CYCLES > 3) ? $clog2(PAD_CYCLES + 1) : 2;
    localparam logic [CNT_W-1:0] PAD_MAX   = CNT_W'(PAD_CYCLES);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-2:0] addr_sh;
    // Cleared by reset; a packet may only start once frame_n has been seen high,
    // so the tail of a packet cut by reset is never mistaken for a new header.
    logic              armed;

    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            addr_sh  <= '0;
            armed    <= 1'b0;
            addr     <= '0;
            addr_vld <= 1'b0;
            frameo_n <= 1'b1;
            valido_n <= 1'b1;
            dout     <= 1'b0;
            pkt_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            pkt_err  <= 1'b0;
            frameo_n <= 1'b1;
            valido_n <= 1'b1;
            dout     <= 1'b0;
            armed    <= armed | frame_n;

            unique case (state)
                S_IDLE: begin
                    addr_vld <= 1'b0;
                    if (armed && !frame_n) begin
                        busy <= 1'b1;
                        if (!valid_n) begin
                            // Suppressed right after a previous error so pulses never merge.
                            pkt_err <= !pkt_err;
                            state   <= S_DROP;
                        end else begin
                            addr_sh <= {din, addr_sh[ADDR_W-2:1]};
                            cnt     <= CNT_ONE;
                            state   <= S_ADDR;
                        end
                    end
                end

                S_ADDR: begin
                    addr_vld <= 1'b0;
                    if (frame_n) begin
                        pkt_err <= 1'b1;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else if (!valid_n) begin
                        pkt_err <= 1'b1;
                        cnt     <= '0;
                        state   <= S_DROP;
                    end else if (cnt == ADDR_LAST) begin
                        addr     <= {din, addr_sh};
                        addr_vld <= 1'b1;
                        cnt      <= '0;
                        state    <= S_PAD;
                    end else begin
                        addr_sh <= {din, addr_sh[ADDR_W-2:1]};
                        cnt     <= cnt + CNT_ONE;
                    end
                end

                S_PAD: begin
                    if (frame_n) begin
                        pkt_err  <= 1'b1;
                        addr_vld <= 1'b0;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (valid_n) begin
                        if (cnt != PAD_MAX)
                            cnt <= cnt + CNT_ONE;
                    end else if (cnt != PAD_MAX) begin
                        pkt_err  <= 1'b1;
                        addr_vld <= 1'b0;
                        cnt      <= '0;
                        state    <= S_DROP;
                    end else begin
                        dout     <= din;
                        valido_n <= 1'b0;
                        frameo_n <= 1'b0;
                        cnt      <= '0;
                        state    <= S_DATA;
                    end
                end

                S_DATA: begin
                    dout     <= din;
                    valido_n <= valid_n;
                    frameo_n <= frame_n;
                    if (frame_n) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                S_DROP: begin
                    addr_vld <= 1'b0;
                    if (frame_n) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    addr_vld <= 1'b0;
                    cnt      <= '0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_input_port.sv
// Directed bench for router_input_port: normal packets, back-to-back traffic,
// padding/address protocol errors, mid-packet reset and data bubbles.
module tb_router_input_port;
    import router_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_n;
    logic       valid_n;
    logic       din;
    logic [3:0] addr;
    logic       addr_vld;
    logic       frameo_n;
    logic       valido_n;
    logic       dout;
    logic       pkt_err;
    logic       busy;
    logic [2:0] fsm_state;

    int tests = 0;
    int fails = 0;

    router_input_port #(.PAD_CYCLES(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .frame_n   (frame_n),
        .valid_n   (valid_n),
        .din       (din),
        .addr      (addr),
        .addr_vld  (addr_vld),
        .frameo_n  (frameo_n),
        .valido_n  (valido_n),
        .dout      (dout),
        .pkt_err   (pkt_err),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; return 1 time unit after the capturing edge.
    task automatic step(input logic f, input logic v, input logic d);
        frame_n = f;
        valid_n = v;
        din     = d;
        @(posedge clock);
        #1;
    endtask

    task automatic send_addr(input logic [3:0] a);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, a[i]);
    endtask

    task automatic send_pad(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    // Drive one data-phase cycle; the registered outputs must echo it.
    task automatic data_bit(input string tag, input logic f, input logic v, input logic d);
        step(f, v, d);
        check({tag, "_dout"}, dout, d);
        check({tag, "_valido"}, valido_n, v);
        check({tag, "_frameo"}, frameo_n, f);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_frameo"}, frameo_n, 1'b1);
        check({tag, "_valido"}, valido_n, 1'b1);
        check({tag, "_dout"}, dout, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, fsm_state, S_IDLE);
        check({tag, "_addr"}, addr, 4'd0);
        check({tag, "_addr_vld"}, addr_vld, 1'b0);
        check({tag, "_pkt_err"}, pkt_err, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check_quiet(tag);
    endtask

    initial begin
        reset = 1'b1; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_reset_vals("rst");
        reset = 1'b0;
        step(1'b1, 1'b1, 0);
        check("idle_busy", busy, 1'b0);

        // Basic packet to 4'b1010 with exactly 5 padding cycles.
        send_addr(4'b1010);
        check("p1_addr", addr, 4'd10);
        check("p1_addr_vld", addr_vld, 1'b1);
        check("p1_state_pad", fsm_state, S_PAD);
        check("p1_busy", busy, 1'b1);
        send_pad(5);
        check_quiet("p1_pad");
        data_bit("p1_d0", 1'b0, 1'b0, 1'b1);
        check("p1_state_data", fsm_state, S_DATA);
        data_bit("p1_d1", 1'b0, 1'b0, 1'b0);
        data_bit("p1_d2", 1'b1, 1'b0, 1'b1);
        check("p1_last_addr_vld", addr_vld, 1'b1);
        check("p1_end_state", fsm_state, S_IDLE);
        step(1'b1, 1'b1, 1'b0);
        check_quiet("p1_after");
        check("p1_after_addr_vld", addr_vld, 1'b0);
        check("p1_after_busy", busy, 1'b0);

        // Back-to-back packets to 3 then 12.
        send_addr(4'd3);
        check("b2b_addr3", addr, 4'd3);
        send_pad(5);
        data_bit("b2b_a_d0", 1'b0, 1'b0, 1'b1);
        data_bit("b2b_a_d1", 1'b0, 1'b0, 1'b0);
        data_bit("b2b_a_d2", 1'b1, 1'b0, 1'b1);
        check("b2b_a_last_vld", addr_vld, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("b2b_second_start", fsm_state, S_ADDR);
        check("b2b_vld_fall", addr_vld, 1'b0);
        check("b2b_addr_hold", addr, 4'd3);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("b2b_addr12", addr, 4'd12);
        check("b2b_vld12", addr_vld, 1'b1);
        send_pad(5);
        data_bit("b2b_b_d0", 1'b0, 1'b0, 1'b0);
        data_bit("b2b_b_d1", 1'b0, 1'b0, 1'b1);
        data_bit("b2b_b_d2", 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check_quiet("b2b_after");

        // Early valid on the 3rd padding cycle.
        send_addr(4'd5);
        check("pe_addr", addr, 4'd5);
        send_pad(2);
        step(1'b0, 1'b0, 1'b1);
        check("pe_err", pkt_err, 1'b1);
        check("pe_state", fsm_state, S_DROP);
        check("pe_vld", addr_vld, 1'b0);
        check_quiet("pe_err_cyc");
        step(1'b0, 1'b0, 1'b0);
        check("pe_err_once", pkt_err, 1'b0);
        check("pe_drop_hold", fsm_state, S_DROP);
        check_quiet("pe_drop");
        step(1'b1, 1'b0, 1'b1);
        check("pe_idle", fsm_state, S_IDLE);
        check_quiet("pe_idle");
        step(1'b1, 1'b1, 1'b0);

        // frame_n rises during the 2nd address bit.
        step(1'b0, 1'b1, 1'b1);
        check("fe_addr_state", fsm_state, S_ADDR);
        step(1'b1, 1'b1, 1'b0);
        check("fe_err", pkt_err, 1'b1);
        check("fe_state", fsm_state, S_IDLE);
        check("fe_addr_kept", addr, 4'd5);
        check_quiet("fe");
        step(1'b1, 1'b1, 1'b0);
        check("fe_err_once", pkt_err, 1'b0);

        // Two-cycle bubble mid-data, 7 padding cycles (count saturates).
        send_addr(4'd9);
        check("bb_addr", addr, 4'd9);
        send_pad(7);
        data_bit("bb_d0", 1'b0, 1'b0, 1'b1);
        data_bit("bb_d1", 1'b0, 1'b0, 1'b0);
        data_bit("bb_bub0", 1'b0, 1'b1, 1'b0);
        data_bit("bb_bub1", 1'b0, 1'b1, 1'b0);
        data_bit("bb_d2", 1'b0, 1'b0, 1'b1);
        data_bit("bb_d3", 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check_quiet("bb_after");

        // Reset on the 4th data bit of an 8-bit packet, then a clean packet.
        send_addr(4'd6);
        check("rp_addr", addr, 4'd6);
        send_pad(5);
        data_bit("rp_d0", 1'b0, 1'b0, 1'b1);
        data_bit("rp_d1", 1'b0, 1'b0, 1'b1);
        data_bit("rp_d2", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        check_reset_vals("rp_rst");
        step(1'b0, 1'b0, 1'b1);
        check("rp_ign4_state", fsm_state, S_IDLE);
        check_quiet("rp_ign4");
        step(1'b0, 1'b0, 1'b0);
        check("rp_ign5_err", pkt_err, 1'b0);
        check_quiet("rp_ign5");
        step(1'b0, 1'b0, 1'b1);
        check("rp_ign6_busy", busy, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("rp_ign7_state", fsm_state, S_IDLE);
        check_quiet("rp_ign7");
        send_addr(4'd4);
        check("rp_next_addr", addr, 4'd4);
        check("rp_next_vld", addr_vld, 1'b1);
        send_pad(5);
        data_bit("rp_n_d0", 1'b0, 1'b0, 1'b1);
        data_bit("rp_n_d1", 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_quiet("rp_after");
        check("rp_after_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
